// File: rtl/acum_diff.sv
// ---------------------------------------------------------------------------
// acum_diff
//
// Inverse of the running-sum accumulator. Each accepted accumulated value is
// differenced (modulo 2^NB_ACC) against the previously accepted one, which
// recovers the original sample. Results leave through a one-deep output
// register with a valid/ready handshake, one cycle after acceptance.
// Differences too large for the sample width saturate to all ones and set a
// sticky range error.
//
// Ports:
//   e_clk        clock, rising edge
//   e_reset      asynchronous active-high reset
//   e_acc        accumulated value from upstream
//   e_valid      e_acc valid
//   s_ready      block can accept e_acc this cycle
//   e_clear      synchronous restart: upstream accumulator went back to 0
//   s_data       recovered sample (NB_INPUT+1 bits)
//   s_valid      s_data valid
//   e_ready      downstream accepts s_data
//   s_range_err  sticky: a difference exceeded the sample range
//   s_count      number of completed output handshakes, wraps
//
// States:
//   ST_PRIME | waiting for the first value; it only loads the history
//   ST_RUN   | every accepted value produces a difference
// ---------------------------------------------------------------------------
module acum_diff #(
    parameter int NB_INPUT = 3,
    parameter int NB_ACC   = NB_INPUT + 4,
    parameter int NB_CNT   = 8,
    parameter bit PRIME_EN = 1'b1
) (
    input  logic                e_clk,
    input  logic                e_reset,
    input  logic [NB_ACC-1:0]   e_acc,
    input  logic                e_valid,
    output logic                s_ready,
    input  logic                e_clear,
    output logic [NB_INPUT:0]   s_data,
    output logic                s_valid,
    input  logic                e_ready,
    output logic                s_range_err,
    output logic [NB_CNT-1:0]   s_count
);

    localparam int NB_OUT = NB_INPUT + 1;
    // Largest difference that still fits in the recovered sample width.
    localparam logic [NB_ACC-1:0] MAX_SAMPLE = NB_ACC'((2 ** NB_OUT) - 1);

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NB_ACC-1:0]   prev_q, prev_d;
    logic [NB_OUT-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [NB_CNT-1:0]   count_q, count_d;

    logic [NB_ACC-1:0]   diff;
    logic                ready_c;
    logic                accept;
    logic                emit;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge e_clk or posedge e_reset) begin
        if (e_reset) begin
            if (PRIME_EN) begin
                state_q <= ST_PRIME;
            end else begin
                state_q <= ST_RUN;
            end
            prev_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / handshake logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Natural wrap of the subtraction gives the modular difference.
        diff    = e_acc - prev_q;
        emit    = valid_q & e_ready;

        // The output register frees up in the same cycle it is drained, so an
        // accept alongside an emit keeps one sample per clock.
        if (e_clear) begin
            ready_c = 1'b0;
        end else if (state_q == ST_PRIME) begin
            ready_c = 1'b1;
        end else begin
            ready_c = ~valid_q | e_ready;
        end
        accept  = e_valid & ready_c;

        state_d = state_q;
        prev_d  = prev_q;
        data_d  = data_q;
        valid_d = valid_q & ~emit;
        err_d   = err_q;
        count_d = count_q + NB_CNT'(emit);

        if (e_clear) begin
            // Upstream restarted from zero: history follows, any pending
            // sample is dropped; the emitted-sample count is kept.
            state_d = ST_RUN;
            prev_d  = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            prev_d = e_acc;
            case (state_q)
                ST_PRIME: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    valid_d = 1'b1;
                    if (diff > MAX_SAMPLE) begin
                        data_d = '1;
                        err_d  = 1'b1;
                    end else begin
                        data_d = diff[NB_OUT-1:0];
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign s_ready     = ready_c;
    assign s_data      = data_q;
    assign s_valid     = valid_q;
    assign s_range_err = err_q;
    assign s_count     = count_q;

endmodule

// File: tb/tb_acum_diff.sv
module tb_acum_diff;

    localparam int NB_INPUT = 3;
    localparam int NB_ACC   = 7;
    localparam int NB_CNT   = 8;
    localparam int ACC_MOD  = 128;
    localparam int SAT      = 15;

    logic                e_clk = 1'b0;
    logic                e_reset = 1'b0;
    logic [NB_ACC-1:0]   e_acc = '0;
    logic                e_valid = 1'b0;
    logic                s_ready;
    logic                e_clear = 1'b0;
    logic [NB_INPUT:0]   s_data;
    logic                s_valid;
    logic                e_ready = 1'b0;
    logic                s_range_err;
    logic [NB_CNT-1:0]   s_count;

    acum_diff #(
        .NB_INPUT (NB_INPUT),
        .NB_ACC   (NB_ACC),
        .NB_CNT   (NB_CNT),
        .PRIME_EN (1'b1)
    ) dut (
        .e_clk       (e_clk),
        .e_reset     (e_reset),
        .e_acc       (e_acc),
        .e_valid     (e_valid),
        .s_ready     (s_ready),
        .e_clear     (e_clear),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .e_ready     (e_ready),
        .s_range_err (s_range_err),
        .s_count     (s_count)
    );

    always #5 e_clk = ~e_clk;

    // Reference model: samples waiting downstream, last accepted value,
    // whether the next value only primes, sticky error, handshake count.
    int  exp_q[$];
    int  m_prev;
    bit  m_priming;
    bit  m_err;
    int  m_count;
    bit  last_accept;

    int  n_cmp  = 0;
    int  n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prev    = 0;
        m_priming = 1'b1;
        m_err     = 1'b0;
        m_count   = 0;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".s_valid"}, 32'(s_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check({where, ".s_data"}, 32'(s_data), 32'(exp_q[0]));
        check({where, ".s_count"}, 32'(s_count), 32'(m_count));
        check({where, ".s_range_err"}, 32'(s_range_err), 32'(m_err));
    endtask

    // One clock: drive at negedge, check ready, advance model, check at posedge+1.
    task automatic cycle(input string where, input bit v, input int a, input bit r, input bit c);
        bit exp_rdy;
        int d;
        @(negedge e_clk);
        e_valid = v;
        e_acc   = NB_ACC'(a);
        e_ready = r;
        e_clear = c;
        #1;
        exp_rdy = !c && (m_priming || exp_q.size() == 0 || r);
        check({where, ".s_ready"}, 32'(s_ready), 32'(exp_rdy));
        last_accept = v && exp_rdy;
        if (exp_q.size() > 0 && r) begin
            void'(exp_q.pop_front());
            m_count = (m_count + 1) % 256;
        end
        if (c) begin
            exp_q.delete();
            m_prev    = 0;
            m_err     = 1'b0;
            m_priming = 1'b0;
        end else if (last_accept) begin
            if (m_priming) begin
                m_priming = 1'b0;
            end else begin
                d = (a - m_prev + ACC_MOD) % ACC_MOD;
                if (d > SAT) begin
                    exp_q.push_back(SAT);
                    m_err = 1'b1;
                end else begin
                    exp_q.push_back(d);
                end
            end
            m_prev = a;
        end
        @(posedge e_clk);
        #1;
        check_outputs(where);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset(input string where);
        @(negedge e_clk);
        e_valid = 1'b0;
        e_clear = 1'b0;
        e_ready = 1'b0;
        #2 e_reset = 1'b1;
        #1;
        check({where, ".s_valid"}, 32'(s_valid), 32'd0);
        check({where, ".s_data"}, 32'(s_data), 32'd0);
        check({where, ".s_count"}, 32'(s_count), 32'd0);
        check({where, ".s_range_err"}, 32'(s_range_err), 32'd0);
        #1 e_reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int cur_acc;
        bit up_pend;
        int sample;
        bit clr;
        bit rdy;

        // Power-on reset, checked before any clock edge
        e_reset = 1'b1;
        #1;
        check("por.s_valid", 32'(s_valid), 32'd0);
        check("por.s_data", 32'(s_data), 32'd0);
        check("por.s_count", 32'(s_count), 32'd0);
        check("por.s_range_err", 32'(s_range_err), 32'd0);
        check("por.s_ready", 32'(s_ready), 32'd1);
        @(negedge e_clk);
        e_reset = 1'b0;
        model_reset();

        // Priming: 10 loads history, then 3 and 7
        cycle("prime0", 1, 10, 1, 0);
        cycle("prime1", 1, 13, 1, 0);
        cycle("prime2", 1, 20, 1, 0);
        cycle("prime3", 0, 20, 1, 0);

        // Wrap-around: prime with 125, then 4 -> 7
        async_reset("rst_wrap");
        cycle("wrap0", 1, 125, 1, 0);
        cycle("wrap1", 1, 4, 1, 0);
        cycle("wrap2", 0, 4, 1, 0);

        // Range error: clear, 20 saturates, 25 -> 5 with error held
        cycle("rng_clr", 0, 0, 1, 1);
        cycle("rng0", 1, 20, 1, 0);
        cycle("rng1", 1, 25, 1, 0);
        cycle("rng2", 0, 25, 1, 0);

        // Backpressure: 1 primes, 2 held three cycles, then 3 and 4
        async_reset("rst_bp");
        cycle("bp0", 1, 1, 1, 0);
        cycle("bp1", 1, 3, 1, 0);
        cycle("bp_hold0", 1, 6, 0, 0);
        cycle("bp_hold1", 1, 6, 0, 0);
        cycle("bp_hold2", 1, 6, 0, 0);
        cycle("bp2", 1, 6, 1, 0);
        cycle("bp3", 1, 10, 1, 0);
        cycle("bp4", 0, 10, 1, 0);

        // Clear collision: 50 dropped, then 9 -> 9
        cycle("col0", 1, 50, 1, 1);
        cycle("col1", 1, 9, 1, 0);
        cycle("col2", 1, 12, 1, 0);
        cycle("col3", 1, 14, 1, 0);
        check("pre_rst.s_count", 32'(s_count), 32'd5);
        check("pre_rst.s_valid", 32'(s_valid), 32'd1);

        // Async reset mid-transfer, then the first sample primes again
        async_reset("rst_mid");
        cycle("post0", 1, 30, 1, 0);
        cycle("post1", 1, 33, 1, 0);

        // Randomized stream with occasional clears and large jumps
        cur_acc = 33;
        up_pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!up_pend && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 9) == 0) sample = int'($urandom_range(16, 60));
                else sample = int'($urandom_range(0, 15));
                cur_acc = (cur_acc + sample) % ACC_MOD;
                up_pend = 1'b1;
            end
            clr = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            cycle("rand", up_pend, cur_acc, rdy, clr);
            if (clr) begin
                up_pend = 1'b0;
                cur_acc = 0;
            end else if (last_accept) begin
                up_pend = 1'b0;
            end
        end
        cycle("drain", 0, cur_acc, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
